// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the fft_part1 batch sequencer: state encoding,
// block geometry and the default watchdog limit.
package fft_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      LOAD  = 3'd2,
      RUN   = 3'd3,
      DRAIN = 3'd4,
      FIN   = 3'd5
   } ctrl_state_t;

   localparam int WORDS_PER_BLK      = 8;
   localparam int TIMEOUT_CYCLES_DEF = 256;

   // Counter width that never collapses to zero bits.
   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/fft_ctrl_wdog.sv
// Watchdog counter for the RUN wait of fft_part1_ctrl; exists only when
// FFT_PART1_CTRL_TIMEOUT_EN is defined.
`ifdef FFT_PART1_CTRL_TIMEOUT_EN
module fft_ctrl_wdog
   import fft_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr) begin
         cnt_reg <= '0;
      end else if (en && !expired) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   // Fires on the TIMEOUT_CYCLES-th enabled cycle since the last clear.
   assign expired = en && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/fft_part1_ctrl.sv
// Batch sequencer for fft_part1: fetch block, start, wait done, drain results.
// Optional RUN watchdog with sticky err_o: define FFT_PART1_CTRL_TIMEOUT_EN.
module fft_part1_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int DIN_W          = 256,
   parameter int DOUT_W         = 32,
   parameter int WORDS_PER_BLK  = fft_ctrl_pkg::WORDS_PER_BLK,
   parameter int RD_ADDR_W      = 6,
   parameter int WR_ADDR_W      = 9,
   parameter int NBLK_W         = 7,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [NBLK_W-1:0]    num_blocks_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic                 rd_en_o,
   output logic [RD_ADDR_W-1:0] rd_addr_o,
   input  logic [DIN_W-1:0]     rd_data_i,
   output logic                 wr_en_o,
   output logic [WR_ADDR_W-1:0] wr_addr_o,
   output logic [DOUT_W-1:0]    wr_data_o,
   input  logic                 wr_ready_i,
   output logic                 fft_start_o,
   output logic [DIN_W-1:0]     fft_din_o,
   input  logic                 fft_done_i,
   input  logic [DOUT_W-1:0]    fft_dout_i,
   output logic                 fft_dout_read_o
);

   localparam int WORD_W = clog2_min1(WORDS_PER_BLK);

   ctrl_state_t       state_reg;
   logic [NBLK_W-1:0] blk_reg;
   logic [NBLK_W-1:0] num_reg;
   logic [WORD_W-1:0] word_reg;
   logic              wdog_expired;

   wire last_word = (word_reg == WORD_W'(WORDS_PER_BLK - 1));
   wire last_blk  = (blk_reg == num_reg - NBLK_W'(1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         blk_reg   <= '0;
         num_reg   <= '0;
         word_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_i) begin
                  num_reg   <= num_blocks_i;
                  blk_reg   <= '0;
                  state_reg <= (num_blocks_i == '0) ? FIN : RD;
               end
            end
            RD:   state_reg <= LOAD;
            LOAD: state_reg <= RUN;
            RUN: begin
               if (fft_done_i) begin
                  word_reg  <= '0;
                  state_reg <= DRAIN;
               end else if (wdog_expired) begin
                  state_reg <= FIN;
               end
            end
            DRAIN: begin
               // Backpressure: nothing moves until the output RAM takes the word.
               if (wr_ready_i) begin
                  if (!last_word) begin
                     word_reg <= word_reg + WORD_W'(1);
                  end else if (last_blk) begin
                     state_reg <= FIN;
                  end else begin
                     blk_reg   <= blk_reg + NBLK_W'(1);
                     state_reg <= RD;
                  end
               end
            end
            FIN:     state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o          = (state_reg != IDLE);
      done_o          = (state_reg == FIN);
      rd_en_o         = 1'b0;
      rd_addr_o       = '0;
      fft_start_o     = 1'b0;
      fft_din_o       = '0;
      wr_en_o         = 1'b0;
      wr_addr_o       = '0;
      wr_data_o       = '0;
      fft_dout_read_o = 1'b0;
      case (state_reg)
         RD: begin
            rd_en_o   = 1'b1;
            rd_addr_o = RD_ADDR_W'(blk_reg);
         end
         LOAD: begin
            fft_start_o = 1'b1;
            fft_din_o   = rd_data_i;
         end
         DRAIN: begin
            wr_en_o         = 1'b1;
            wr_addr_o       = WR_ADDR_W'(blk_reg) * WR_ADDR_W'(WORDS_PER_BLK)
                              + WR_ADDR_W'(word_reg);
            wr_data_o       = fft_dout_i;
            fft_dout_read_o = wr_ready_i;
         end
         default: ;
      endcase
   end

`ifdef FFT_PART1_CTRL_TIMEOUT_EN
   logic err_reg;

   // Counter restarts while in LOAD, i.e. on every entry to RUN.
   fft_ctrl_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr    (state_reg == LOAD),
      .en     (state_reg == RUN),
      .expired(wdog_expired)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_reg <= 1'b0;
      end else if (state_reg == IDLE && start_i) begin
         err_reg <= 1'b0;
      end else if (state_reg == RUN && !fft_done_i && wdog_expired) begin
         err_reg <= 1'b1;
      end
   end

   assign err_o = err_reg;
`else
   logic unused_timeout_cfg;

   assign wdog_expired       = 1'b0;
   assign err_o              = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule
